// File: rtl/rx_frame_sched.sv
// Receive frame scheduler: sweeps the enabled DDC channels once per sample,
// writes I/Q/IQ3 words to the frame buffer, and closes each frame with a
// timestamp + counter trailer. Tracks completed and unread frames, and raises
// sticky overrun / missed-sample flags.
module rx_frame_sched #(
    parameter int unsigned N_CHANS  = 4,
    parameter int unsigned MAX_PEND = 8
) (
    input  logic                                               adc_clk,
    input  logic                                               rst_n,
    input  logic                                               rx_avail,
    input  logic [N_CHANS-1:0]                                 chan_en,
    input  logic [7:0]                                         nrx_samps,
    input  logic                                               rd_done,
    input  logic                                               clr_err,
    output logic                                               rd_i,
    output logic                                               rd_q,
    output logic [((N_CHANS > 1) ? $clog2(N_CHANS) : 1)-1:0]  chan_sel,
    output logic [1:0]                                         word_sel,
    output logic [1:0]                                         tsel,
    output logic                                               wr,
    output logic                                               ticks_latch,
    output logic                                               frame_done,
    output logic [15:0]                                        buf_ctr,
    output logic [3:0]                                         pending,
    output logic                                               overrun,
    output logic                                               samp_miss,
    output logic                                               busy
);

    localparam int unsigned CW = (N_CHANS > 1) ? $clog2(N_CHANS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_TS0,
        ST_TS1,
        ST_TS2,
        ST_CTR,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_I,
        PH_Q,
        PH_IQ3
    } phase_e;

    state_e               state_q, state_d;
    phase_e               ph_q, ph_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [7:0]           count_q, count_d;
    logic [7:0]           nsamps_q, nsamps_d;
    logic [N_CHANS-1:0]   en_q, en_d;
    logic                 drop_q, drop_d;
    logic [15:0]          buf_ctr_q, buf_ctr_d;
    logic [3:0]           pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 samp_miss_q, samp_miss_d;

    logic                 rd_i_q, rd_i_d;
    logic                 rd_q_q, rd_q_d;
    logic [CW-1:0]        chan_sel_q, chan_sel_d;
    logic [1:0]           word_sel_q, word_sel_d;
    logic [1:0]           tsel_q, tsel_d;
    logic                 wr_q, wr_d;
    logic                 tl_q, tl_d;
    logic                 fdone_q, fdone_d;
    logic                 busy_q, busy_d;

    logic                 ovr_evt;
    logic                 miss_evt;
    logic                 inc;
    logic [7:0]           cnt_inc;
    logic [CW:0]          first;
    logic [CW:0]          nxt;

    // Lowest enabled channel at or above start; MSB of result flags a hit.
    function automatic logic [CW:0] find_en(input logic [N_CHANS-1:0] mask,
                                            input int unsigned start);
        logic [CW:0] res;
        res = '0;
        for (int unsigned i = 0; i < N_CHANS; i++) begin
            if (!res[CW] && (i >= start) && mask[i]) begin
                res = {1'b1, CW'(i)};
            end
        end
        return res;
    endfunction

    assign cnt_inc = count_q + 8'd1;

    // Next-state, frame bookkeeping and next registered output values.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        ch_d        = ch_q;
        count_d     = count_q;
        nsamps_d    = nsamps_q;
        en_d        = en_q;
        drop_d      = drop_q;
        buf_ctr_d   = buf_ctr_q;
        pending_d   = pending_q;
        ovr_evt     = 1'b0;
        miss_evt    = 1'b0;
        inc         = 1'b0;
        tl_d        = 1'b0;
        first       = '0;
        nxt         = '0;
        rd_i_d      = 1'b0;
        rd_q_d      = 1'b0;
        chan_sel_d  = '0;
        word_sel_d  = 2'd0;
        tsel_d      = 2'd0;
        wr_d        = 1'b0;
        fdone_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_avail) begin
                    if (count_q == 8'd0) begin
                        en_d     = chan_en;
                        nsamps_d = (nrx_samps == 8'd0) ? 8'd1 : nrx_samps;
                        drop_d   = (pending_q == 4'(MAX_PEND));
                        ovr_evt  = drop_d;
                    end
                    first   = find_en(en_d, 0);
                    ch_d    = first[CW] ? first[CW-1:0] : '0;
                    ph_d    = PH_I;
                    state_d = ST_SWEEP;
                    tl_d    = (cnt_inc == nsamps_d);
                end
            end
            ST_SWEEP: begin
                // A disabled current channel only happens with an empty mask:
                // that sample spends one idle cycle here and then counts.
                nxt = find_en(en_q, 32'(ch_q) + 32'd1);
                if (!en_q[ch_q] || (ph_q == PH_IQ3)) begin
                    if (nxt[CW]) begin
                        ch_d = nxt[CW-1:0];
                        ph_d = PH_I;
                    end else begin
                        count_d = cnt_inc;
                        state_d = (cnt_inc < nsamps_q) ? ST_IDLE : ST_TS0;
                    end
                end else begin
                    ph_d = (ph_q == PH_I) ? PH_Q : PH_IQ3;
                end
            end
            ST_TS0:  state_d = ST_TS1;
            ST_TS1:  state_d = ST_TS2;
            ST_TS2:  state_d = ST_CTR;
            ST_CTR:  state_d = ST_DONE;
            ST_DONE: begin
                count_d = 8'd0;
                inc     = !drop_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_avail && (state_q != ST_IDLE)) begin
            miss_evt = 1'b1;
        end

        buf_ctr_d = buf_ctr_q + 16'(inc);
        if (inc && !rd_done) begin
            pending_d = pending_q + 4'd1;
        end else if (!inc && rd_done && (pending_q != 4'd0)) begin
            pending_d = pending_q - 4'd1;
        end

        overrun_d   = (overrun_q & ~clr_err) | ovr_evt;
        samp_miss_d = (samp_miss_q & ~clr_err) | miss_evt;

        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_SWEEP: begin
                if (en_d[ch_d]) begin
                    chan_sel_d = ch_d;
                    tsel_d     = 2'(ph_d);
                    rd_i_d     = (ph_d == PH_I);
                    rd_q_d     = (ph_d == PH_Q);
                    wr_d       = !drop_d;
                end
            end
            ST_TS0: begin
                wr_d = !drop_d; word_sel_d = 2'd1; tsel_d = 2'd0;
            end
            ST_TS1: begin
                wr_d = !drop_d; word_sel_d = 2'd1; tsel_d = 2'd1;
            end
            ST_TS2: begin
                wr_d = !drop_d; word_sel_d = 2'd1; tsel_d = 2'd2;
            end
            ST_CTR: begin
                wr_d = !drop_d; word_sel_d = 2'd2;
            end
            ST_DONE: fdone_d = !drop_d;
            default: ;
        endcase
    end

    // State, frame context, counters, flags and output registers.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ph_q        <= PH_I;
            ch_q        <= '0;
            count_q     <= 8'd0;
            nsamps_q    <= 8'd1;
            en_q        <= '0;
            drop_q      <= 1'b0;
            buf_ctr_q   <= 16'd0;
            pending_q   <= 4'd0;
            overrun_q   <= 1'b0;
            samp_miss_q <= 1'b0;
            rd_i_q      <= 1'b0;
            rd_q_q      <= 1'b0;
            chan_sel_q  <= '0;
            word_sel_q  <= 2'd0;
            tsel_q      <= 2'd0;
            wr_q        <= 1'b0;
            tl_q        <= 1'b0;
            fdone_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            ch_q        <= ch_d;
            count_q     <= count_d;
            nsamps_q    <= nsamps_d;
            en_q        <= en_d;
            drop_q      <= drop_d;
            buf_ctr_q   <= buf_ctr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            samp_miss_q <= samp_miss_d;
            rd_i_q      <= rd_i_d;
            rd_q_q      <= rd_q_d;
            chan_sel_q  <= chan_sel_d;
            word_sel_q  <= word_sel_d;
            tsel_q      <= tsel_d;
            wr_q        <= wr_d;
            tl_q        <= tl_d;
            fdone_q     <= fdone_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_i        = rd_i_q;
    assign rd_q        = rd_q_q;
    assign chan_sel    = chan_sel_q;
    assign word_sel    = word_sel_q;
    assign tsel        = tsel_q;
    assign wr          = wr_q;
    assign ticks_latch = tl_q;
    assign frame_done  = fdone_q;
    assign buf_ctr     = buf_ctr_q;
    assign pending     = pending_q;
    assign overrun     = overrun_q;
    assign samp_miss   = samp_miss_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rx_frame_sched.sv
// Scoreboard bench for rx_frame_sched: a frame-level model queues the buffer
// words each accepted sample should produce; a monitor pops them on every wr.
module tb_rx_frame_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned MP  = 8;

    logic            adc_clk   = 1'b0;
    logic            rst_n     = 1'b0;
    logic            rx_avail  = 1'b0;
    logic [NCH-1:0]  chan_en   = '0;
    logic [7:0]      nrx_samps = 8'd0;
    logic            rd_done   = 1'b0;
    logic            clr_err   = 1'b0;

    logic            rd_i, rd_q, wr, ticks_latch, frame_done;
    logic            overrun, samp_miss, busy;
    logic [1:0]      chan_sel, word_sel, tsel;
    logic [15:0]     buf_ctr;
    logic [3:0]      pending;

    rx_frame_sched #(.N_CHANS(NCH), .MAX_PEND(MP)) dut (
        .adc_clk(adc_clk), .rst_n(rst_n), .rx_avail(rx_avail),
        .chan_en(chan_en), .nrx_samps(nrx_samps), .rd_done(rd_done),
        .clr_err(clr_err), .rd_i(rd_i), .rd_q(rd_q), .chan_sel(chan_sel),
        .word_sel(word_sel), .tsel(tsel), .wr(wr), .ticks_latch(ticks_latch),
        .frame_done(frame_done), .buf_ctr(buf_ctr), .pending(pending),
        .overrun(overrun), .samp_miss(samp_miss), .busy(busy)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct packed {
        logic [1:0] ws;
        logic [1:0] cs;
        logic [1:0] ts;
    } word_t;

    word_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // frame-level reference model
    int             m_count, m_ns, m_pend, m_buf, m_frames, m_rdi, m_ticks;
    logic [NCH-1:0] m_en;
    bit             m_drop, m_ovr, m_miss;

    // observations, cleared while reset is held
    int obs_frames, obs_rdi, obs_ticks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic word_t mkw(input int ws, input int cs, input int ts);
        word_t w;
        w.ws = 2'(ws);
        w.cs = 2'(cs);
        w.ts = 2'(ts);
        return w;
    endfunction

    // Monitor: every buffer write must match the head of the expected queue.
    always @(negedge adc_clk) begin : monitor
        word_t e;
        if (!rst_n) begin
            obs_frames = 0;
            obs_rdi    = 0;
            obs_ticks  = 0;
        end else begin
            if (wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_sel", 32'(word_sel), 32'(e.ws));
                    chk("tsel", 32'(tsel), 32'(e.ts));
                    if (e.ws == 2'd0) chk("chan_sel", 32'(chan_sel), 32'(e.cs));
                end
            end
            if (frame_done)  obs_frames++;
            if (rd_i)        obs_rdi++;
            if (ticks_latch) obs_ticks++;
        end
    end

    task automatic model_reset();
        exp_q.delete();
        m_count = 0; m_ns = 1; m_pend = 0; m_buf = 0; m_frames = 0;
        m_rdi = 0; m_ticks = 0; m_en = '0; m_drop = 0; m_ovr = 0; m_miss = 0;
    endtask

    task automatic apply_reset();
        @(posedge adc_clk);
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge adc_clk);
        @(negedge adc_clk);
        rst_n = 1'b1;
    endtask

    // Accepted sample: model the words it produces, then pulse rx_avail.
    task automatic send_rx();
        if (m_count == 0) begin
            m_en   = chan_en;
            m_ns   = (nrx_samps == 8'd0) ? 1 : int'(nrx_samps);
            m_drop = (m_pend == MP);
            if (m_drop) m_ovr = 1;
        end
        m_rdi += $countones(m_en);
        if (!m_drop) begin
            for (int c = 0; c < NCH; c++)
                if (m_en[c])
                    for (int p = 0; p < 3; p++) exp_q.push_back(mkw(0, c, p));
        end
        m_count++;
        if (m_count == m_ns) begin
            m_ticks++;
            if (!m_drop) begin
                for (int t = 0; t < 3; t++) exp_q.push_back(mkw(1, 0, t));
                exp_q.push_back(mkw(2, 0, 0));
                m_pend++;
                m_buf = (m_buf + 1) & 16'hffff;
                m_frames++;
            end
            m_count = 0;
        end
        @(posedge adc_clk);
        #1 rx_avail = 1'b1;
        @(posedge adc_clk);
        #1 rx_avail = 1'b0;
    endtask

    task automatic wait_frame();
        repeat (3 * $countones(m_en) + 10) @(posedge adc_clk);
    endtask

    task automatic send_rd();
        if (m_pend > 0) m_pend--;
        @(posedge adc_clk);
        #1 rd_done = 1'b1;
        @(posedge adc_clk);
        #1 rd_done = 1'b0;
    endtask

    task automatic pulse_clr();
        m_ovr  = 0;
        m_miss = 0;
        @(posedge adc_clk);
        #1 clr_err = 1'b1;
        @(posedge adc_clk);
        #1 clr_err = 1'b0;
    endtask

    task automatic frame(input logic [NCH-1:0] en, input int ns);
        chan_en   = en;
        nrx_samps = 8'(ns);
        for (int s = 0; s < ((ns == 0) ? 1 : ns); s++) begin
            send_rx();
            wait_frame();
        end
    endtask

    task automatic check_state();
        @(negedge adc_clk);
        chk("buf_ctr", 32'(buf_ctr), 32'(m_buf));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("samp_miss", 32'(samp_miss), 32'(m_miss));
        chk("frame_done_count", 32'(obs_frames), 32'(m_frames));
        chk("rd_i_count", 32'(obs_rdi), 32'(m_rdi));
        chk("ticks_latch_count", 32'(obs_ticks), 32'(m_ticks));
        chk("words_outstanding", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero();
        chk("rst_rd_i", 32'(rd_i), 32'd0);
        chk("rst_rd_q", 32'(rd_q), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_chan_sel", 32'(chan_sel), 32'd0);
        chk("rst_word_sel", 32'(word_sel), 32'd0);
        chk("rst_tsel", 32'(tsel), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_ticks_latch", 32'(ticks_latch), 32'd0);
        chk("rst_buf_ctr", 32'(buf_ctr), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_samp_miss", 32'(samp_miss), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge adc_clk);
        #1 check_all_zero();
        @(negedge adc_clk);
        rst_n = 1'b1;

        // two-sample frame on all channels, samples 40 cycles apart
        chan_en = 4'b1111; nrx_samps = 8'd2;
        send_rx();
        repeat (38) @(posedge adc_clk);
        send_rx();
        wait_frame();
        check_state();

        // sparse mask: channels 0 and 2 only
        frame(4'b0101, 1);
        check_state();

        // fill the buffer, ninth frame dropped, then one read frees a slot
        apply_reset();
        for (int f = 0; f < 9; f++) frame(NCH'($urandom_range(1, 15)), 1);
        check_state();
        send_rd();
        frame(4'b0011, 1);
        check_state();
        pulse_clr();
        check_state();

        // drain, then a read with nothing pending
        for (int r = 0; r < 9; r++) send_rd();
        check_state();

        // read coincident with the frame completion at pending 3
        for (int f = 0; f < 3; f++) frame(4'b1000, 1);
        chan_en = 4'b1111; nrx_samps = 8'd1;
        send_rx();
        repeat (3 * 4 + 4) @(posedge adc_clk);
        #1 chk("frame_done_in_done", 32'(frame_done), 32'd1);
        rd_done = 1'b1;
        if (m_pend > 0) m_pend--;
        @(posedge adc_clk);
        #1 rd_done = 1'b0;
        wait_frame();
        check_state();

        // sample arriving mid-sweep is missed, sweep unaffected
        send_rx();
        repeat (3) @(posedge adc_clk);
        #1 rx_avail = 1'b1;
        m_miss = 1;
        @(posedge adc_clk);
        #1 rx_avail = 1'b0;
        wait_frame();
        check_state();
        pulse_clr();
        check_state();

        // clear coincident with a fresh miss leaves the flag set
        send_rx();
        repeat (2) @(posedge adc_clk);
        #1 rx_avail = 1'b1; clr_err = 1'b1;
        m_miss = 1;
        @(posedge adc_clk);
        #1 rx_avail = 1'b0; clr_err = 1'b0;
        wait_frame();
        check_state();

        // reset during PH_Q of channel 2, then a clean frame
        chan_en = 4'b1111; nrx_samps = 8'd1;
        send_rx();
        repeat (7) @(posedge adc_clk);
        #1 chk("pre_rst_rd_q", 32'(rd_q), 32'd1);
        chk("pre_rst_chan_sel", 32'(chan_sel), 32'd2);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all_zero();
        repeat (3) @(posedge adc_clk);
        @(negedge adc_clk);
        rst_n = 1'b1;
        frame(4'b1111, 1);
        check_state();

        // randomized frames with mid-frame config churn and random reads
        for (int it = 0; it < 40; it++) begin
            chan_en   = NCH'($urandom);
            nrx_samps = 8'($urandom_range(0, 3));
            send_rx();
            wait_frame();
            if ($urandom_range(0, 2) == 0) send_rd();
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end
        while (m_count != 0) begin
            send_rx();
            wait_frame();
        end
        check_state();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
